// File: rtl/psys_route_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : psys_route_pkg
//  Description : Shared helpers and types for the stream router: width
//                helper for the routing counters and the skid entry layout.
//  Revision    : 1.0 - initial release
// ============================================================================
package psys_route_pkg;

    // Default data width of a skid entry when no wider stream is configured.
    localparam int unsigned DEF_WIDTH = 64;

    // Skid entry layout at the default width; the tlast flag sits above the data.
    typedef struct packed {
        logic                 last;
        logic [DEF_WIDTH-1:0] data;
    } skid_entry_t;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_skid2.sv
`default_nettype none
// ============================================================================
//  Module      : axis_skid2
//  Description : Two-entry skid buffer. Output is driven from the head
//                register; ready is a registered "not full" so no
//                combinational path exists from m_ready to s_ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_skid2 #(
    parameter int unsigned WIDTH = 65
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready
);

    logic [WIDTH-1:0] r_hd_data;
    logic             r_hd_valid;
    logic [WIDTH-1:0] r_tl_data;
    logic             r_tl_valid;
    logic             r_ready;

    logic [WIDTH-1:0] w_hd_data;
    logic             w_hd_valid;
    logic [WIDTH-1:0] w_tl_data;
    logic             w_tl_valid;
    logic             w_push;
    logic             w_pop;

    assign w_push  = s_valid & r_ready;
    assign w_pop   = r_hd_valid & m_ready;
    assign s_ready = r_ready;
    assign m_data  = r_hd_data;
    assign m_valid = r_hd_valid;

    // Next-state of the two entries; tail only fills while head is held.
    always_comb begin
        w_hd_data  = r_hd_data;
        w_hd_valid = r_hd_valid;
        w_tl_data  = r_tl_data;
        w_tl_valid = r_tl_valid;
        if (r_tl_valid) begin
            // Full: ready is low, so only a pop can happen.
            if (w_pop) begin
                w_hd_data  = r_tl_data;
                w_tl_valid = 1'b0;
            end
        end else if (r_hd_valid) begin
            if (w_push && w_pop) begin
                w_hd_data = s_data;
            end else if (w_push) begin
                w_tl_data  = s_data;
                w_tl_valid = 1'b1;
            end else if (w_pop) begin
                w_hd_valid = 1'b0;
            end
        end else if (w_push) begin
            w_hd_data  = s_data;
            w_hd_valid = 1'b1;
        end
    end

    // Register entries and the not-full status; ready stays low during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hd_data  <= '0;
            r_hd_valid <= 1'b0;
            r_tl_data  <= '0;
            r_tl_valid <= 1'b0;
            r_ready    <= 1'b0;
        end else begin
            r_hd_data  <= w_hd_data;
            r_hd_valid <= w_hd_valid;
            r_tl_data  <= w_tl_data;
            r_tl_valid <= w_tl_valid;
            r_ready    <= ~w_tl_valid;
        end
    end

endmodule
`default_nettype wire

// File: rtl/stream_route.sv
`default_nettype none
// ============================================================================
//  Module      : stream_route
//  Description : Round-robin distributor of one AXI-Stream over NUM_PORTS
//                output streams, BEATS_PER_PORT beats per port per turn,
//                with a two-entry skid buffer per port, packet counter and
//                sticky packet-length error flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_route
    import psys_route_pkg::*;
#(
    parameter int unsigned WIDTH          = 64,
    parameter int unsigned NUM_PORTS      = 4,
    parameter int unsigned BEATS_PER_PORT = 1,
    parameter int unsigned CNT_W          = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           s_tdata,
    input  logic                       s_tvalid,
    input  logic                       s_tlast,
    output logic                       s_tready,
    output logic [NUM_PORTS*WIDTH-1:0] m_tdata,
    output logic [NUM_PORTS-1:0]       m_tvalid,
    output logic [NUM_PORTS-1:0]       m_tlast,
    input  logic [NUM_PORTS-1:0]       m_tready,
    output logic [CNT_W-1:0]           pkt_count,
    output logic                       len_err
);

    localparam int unsigned SEL_W  = clog2_min1(NUM_PORTS);
    localparam int unsigned BEAT_W = clog2_min1(BEATS_PER_PORT);
    localparam logic [SEL_W-1:0]  C_SEL_MAX  = SEL_W'(NUM_PORTS - 1);
    localparam logic [BEAT_W-1:0] C_BEAT_MAX = BEAT_W'(BEATS_PER_PORT - 1);

    logic [SEL_W-1:0]     r_sel;
    logic [BEAT_W-1:0]    r_beat_cnt;
    logic [CNT_W-1:0]     r_pkt_count;
    logic                 r_len_err;

    logic [NUM_PORTS-1:0] w_port_ready;
    logic [NUM_PORTS-1:0] w_push_req;
    logic                 w_s_fire;
    logic                 w_sel_last;
    logic                 w_beat_last;

    // Input ready follows the registered not-full status of the selected port.
    assign s_tready    = w_port_ready[r_sel];
    assign w_s_fire    = s_tvalid & s_tready;
    assign w_sel_last  = (r_sel == C_SEL_MAX);
    assign w_beat_last = (r_beat_cnt == C_BEAT_MAX);
    assign pkt_count   = r_pkt_count;
    assign len_err     = r_len_err;

    generate
        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
            logic [WIDTH:0] w_head;

            assign w_push_req[p] = s_tvalid & (r_sel == SEL_W'(p));

            axis_skid2 #(
                .WIDTH (WIDTH + 1)
            ) u_skid (
                .clk     (clk),
                .rst_n   (rst_n),
                .s_data  ({s_tlast, s_tdata}),
                .s_valid (w_push_req[p]),
                .s_ready (w_port_ready[p]),
                .m_data  (w_head),
                .m_valid (m_tvalid[p]),
                .m_ready (m_tready[p])
            );

            assign m_tlast[p]                 = w_head[WIDTH];
            assign m_tdata[p*WIDTH +: WIDTH]  = w_head[WIDTH-1:0];
        end
    endgenerate

    // Routing state, packet counter and sticky length check, advanced per accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel       <= '0;
            r_beat_cnt  <= '0;
            r_pkt_count <= '0;
            r_len_err   <= 1'b0;
        end else if (w_s_fire) begin
            if (s_tlast) begin
                r_sel       <= '0;
                r_beat_cnt  <= '0;
                r_pkt_count <= r_pkt_count + 1'b1;
                if (!w_sel_last || !w_beat_last) begin
                    r_len_err <= 1'b1;
                end
            end else if (w_beat_last) begin
                r_beat_cnt <= '0;
                r_sel      <= w_sel_last ? '0 : r_sel + 1'b1;
            end else begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
